// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator (640x480@60 by default).
// Counters and all qualifiers are registered; qualifiers are decoded from the
// next-state counter values so they line up exactly with the coordinates.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       Pclk,
    input  logic       rst_n,
    output logic [9:0] xx,
    output logic [9:0] yy,
    output logic       aactive,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit constants so a total of exactly 1024 still compares correctly
    localparam logic [10:0] C_H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] C_V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] C_H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] C_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] C_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] r_xx;
    logic [9:0] r_yy;
    logic       r_aactive;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_cnt;

    logic       w_x_wrap;
    logic       w_y_wrap;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_aactive;
    logic       w_hsync;
    logic       w_vsync;
    logic       w_line_start;
    logic       w_frame_start;

    // Next raster position and the qualifiers that describe it
    always_comb begin
        w_x_wrap = ({1'b0, r_xx} == C_H_LAST);
        w_y_wrap = ({1'b0, r_yy} == C_V_LAST);
        w_x_next = w_x_wrap ? '0 : r_xx + 10'd1;
        w_y_next = r_yy;
        if (w_x_wrap) begin
            w_y_next = w_y_wrap ? '0 : r_yy + 10'd1;
        end
        w_aactive     = ({1'b0, w_x_next} < C_H_ACT) && ({1'b0, w_y_next} < C_V_ACT);
        w_hsync       = !(({1'b0, w_x_next} >= C_HS_BEG) && ({1'b0, w_x_next} <= C_HS_END));
        w_vsync       = !(({1'b0, w_y_next} >= C_VS_BEG) && ({1'b0, w_y_next} <= C_VS_END));
        w_line_start  = (w_x_next == '0);
        w_frame_start = w_line_start && (w_y_next == '0);
    end

    // Raster registers; reset parks on the last pixel so the first edge opens frame 0
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_xx          <= C_H_LAST[9:0];
            r_yy          <= C_V_LAST[9:0];
            r_aactive     <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_xx          <= w_x_next;
            r_yy          <= w_y_next;
            r_aactive     <= w_aactive;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign xx          = r_xx;
    assign yy          = r_yy;
    assign aactive     = r_aactive;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance (first lines) and a
// shrunken instance (several whole frames) share clock and reset. A reference
// raster model pushes expected outputs before each edge; they are popped and
// compared after the edge.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       a;
        logic       h;
        logic       v;
        logic       ls;
        logic       fs;
        logic [7:0] cnt;
    } obs_t;

    // small instance geometry: 32 x 19 = 608 clocks per frame
    localparam int SH_A = 16, SH_FP = 4, SH_S = 8, SH_BP = 4;
    localparam int SV_A = 12, SV_FP = 2, SV_S = 2, SV_BP = 3;
    localparam int SHT = SH_A + SH_FP + SH_S + SH_BP;
    localparam int SVT = SV_A + SV_FP + SV_S + SV_BP;
    localparam int FHT = 800, FVT = 525;

    logic Pclk = 1'b0;
    logic rst_n = 1'b0;

    logic [9:0] f_xx, f_yy, s_xx, s_yy;
    logic       f_aa, f_hs, f_vs, f_ls, f_fs;
    logic       s_aa, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] f_cnt, s_cnt;

    vga_timing_gen u_full (
        .Pclk(Pclk), .rst_n(rst_n), .xx(f_xx), .yy(f_yy), .aactive(f_aa),
        .hsync(f_hs), .vsync(f_vs), .line_start(f_ls), .frame_start(f_fs),
        .frame_cnt(f_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) u_small (
        .Pclk(Pclk), .rst_n(rst_n), .xx(s_xx), .yy(s_yy), .aactive(s_aa),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs),
        .frame_cnt(s_cnt)
    );

    always #5 Pclk = ~Pclk;

    obs_t obs_full, obs_small;
    assign obs_full  = {f_xx, f_yy, f_aa, f_hs, f_vs, f_ls, f_fs, f_cnt};
    assign obs_small = {s_xx, s_yy, s_aa, s_hs, s_vs, s_ls, s_fs, s_cnt};

    obs_t q_f[$];
    obs_t q_s[$];

    int vectors = 0;
    int miscompares = 0;

    // model state
    int fx, fy, fc, sx, sy, sc;
    // observed statistics
    int cyc = 0;
    int hs_low = 0, hs_first_x = -1, vs_low = 0, bad_act = 0, out_rng = 0;
    int fs_seen = 0, last_fs = 0;

    function automatic obs_t model_out(input int x, input int y, input int cnt,
                                       input int ha, input int hfp, input int hs,
                                       input int va, input int vfp, input int vs);
        obs_t o;
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.a   = (x < ha) && (y < va);
        o.h   = !((x >= ha + hfp) && (x < ha + hfp + hs));
        o.v   = !((y >= va + vfp) && (y < va + vfp + vs));
        o.ls  = (x == 0);
        o.fs  = (x == 0) && (y == 0);
        o.cnt = 8'(cnt);
        return o;
    endfunction

    function automatic obs_t exp_full();
        return model_out(fx, fy, fc, 640, 16, 96, 480, 10, 2);
    endfunction

    function automatic obs_t exp_small();
        return model_out(sx, sy, sc, SH_A, SH_FP, SH_S, SV_A, SV_FP, SV_S);
    endfunction

    task automatic model_reset();
        fx = FHT - 1; fy = FVT - 1; fc = 0;
        sx = SHT - 1; sy = SVT - 1; sc = 0;
    endtask

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b cnt=%0d, expected x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b cnt=%0d",
                   tag, got.x, got.y, got.a, got.h, got.v, got.ls, got.fs, got.cnt,
                   exp.x, exp.y, exp.a, exp.h, exp.v, exp.ls, exp.fs, exp.cnt);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // one clock: advance model, push expectation, wait for edge, pop and compare
    task automatic tick();
        if (rst_n) begin
            fx = (fx + 1) % FHT;
            if (fx == 0) fy = (fy + 1) % FVT;
            if (fx == 0 && fy == 0) fc = (fc + 1) % 256;
            sx = (sx + 1) % SHT;
            if (sx == 0) sy = (sy + 1) % SVT;
            if (sx == 0 && sy == 0) sc = (sc + 1) % 256;
        end
        q_f.push_back(exp_full());
        q_s.push_back(exp_small());
        @(posedge Pclk);
        #1;
        cyc++;
        check_obs("full", obs_full, q_f.pop_front());
        check_obs("small", obs_small, q_s.pop_front());
        if (rst_n) begin
            if (f_yy == 10'd0 && !f_hs) begin
                hs_low++;
                if (hs_low == 1) hs_first_x = int'(f_xx);
            end
            if (s_cnt == 8'd1 && !s_vs) vs_low++;
            if (s_yy >= 10'(SV_A) && s_aa) bad_act++;
            if (f_xx >= 10'(FHT) || f_yy >= 10'(FVT) || s_xx >= 10'(SHT) || s_yy >= 10'(SVT))
                out_rng++;
            if (s_fs) begin
                fs_seen++;
                check_int("small frame_cnt at frame_start", int'(s_cnt), fs_seen);
                if (fs_seen > 1) check_int("frame_start period", cyc - last_fs, SHT * SVT);
                last_fs = cyc;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        model_reset();

        // reset held for 5 clocks
        for (int i = 0; i < 5; i++) tick();

        // release between edges
        #3;
        rst_n = 1'b1;

        // three full-size lines; about four small frames
        for (int i = 0; i < 2400; i++) tick();

        check_int("hsync low clocks line0", hs_low, 96);
        check_int("hsync first low xx", hs_first_x, 656);
        check_int("small vsync low clocks", vs_low, SV_S * SHT);
        check_int("aactive during vblank", bad_act, 0);
        check_int("coordinate out of range", out_rng, 0);
        check_int("small frame_start count", fs_seen, 4);

        // seek to a mid-frame position of the small raster
        found = 1'b0;
        for (int i = 0; i < 2 * SHT * SVT && !found; i++) begin
            if (sx == 9 && sy == 6) found = 1'b1;
            else tick();
        end
        check_int("seek mid-frame position", int'(found), 1);

        // asynchronous reset pulse, not aligned to the clock
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_obs("full async reset", obs_full, exp_full());
        check_obs("small async reset", obs_small, exp_small());
        fs_seen = 0;
        for (int i = 0; i < 2; i++) tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check_int("frame_start after mid reset", fs_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for 640x480 at 60 Hz, clocked by the 25 MHz pixel clock. It produces the `xx`/`yy` pixel coordinates and the `aactive` qualifier consumed by the drawing blocks (playground, sprites, text overlays). It also drives the `hsync`/`vsync` pins and provides per-line and per-frame strobes for animation logic.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `Pclk`  in  1  25 MHz pixel clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `xx`  out  10  current horizontal count, 0..H_TOTAL-1
- `yy`  out  10  current vertical count, 0..V_TOTAL-1
- `aactive`  out  1  high when `xx`<H_ACTIVE and `yy`<V_ACTIVE
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `line_start`  out  1  one-clock strobe when `xx`==0
- `frame_start`  out  1  one-clock strobe when `xx`==0 and `yy`==0
- `frame_cnt`  out  8  frame counter, increments with each `frame_start`

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
  - Both must be ≤1024. An elaboration-time check fails the build otherwise.
- Horizontal counter (`xx`):
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter (`yy`):
  - Advances only on the clock where `xx` wraps.
  - At V_TOTAL-1 (coinciding with the `xx` wrap) it wraps to 0.
- Sync windows:
  - `hsync` is low for `xx` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], high otherwise.
  - `vsync` is low for `yy` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], high otherwise. The window spans whole lines, aligned to the `xx`==0 boundary.
- Output alignment:
  - All outputs are registers.
  - `aactive`, `hsync`, `vsync`, `line_start` and `frame_start` are computed from the next-state counter values. They therefore describe exactly the `xx`/`yy` pair presented in the same cycle, with zero skew between coordinates and qualifiers.
- `frame_cnt` increments, wrapping modulo 256, on the same edge that `frame_start` rises.
- Reset state is the last pixel of a frame, so the first post-reset edge starts frame 0 cleanly. Reset values:
  - `xx`=799, `yy`=524
  - `aactive`=0, `hsync`=1, `vsync`=1
  - `line_start`=0, `frame_start`=0, `frame_cnt`=0
- There are no inputs besides clock and reset. There is no handshake; consumers sample on `Pclk`.

## Timing
- Reset assertion takes effect immediately (asynchronous) and forces all reset values, regardless of raster position.
- First rising edge after `rst_n` deasserts:
  - `xx`=0, `yy`=0, `aactive`=1
  - `line_start`=1, `frame_start`=1, `frame_cnt`=1
- Line period: 800 clocks. `line_start` is high for exactly 1 clock per line.
- Frame period: 800×525 = 420000 clocks. `frame_start` is high for exactly 1 clock per frame.
- Within a line:
  - `aactive` is high for clocks 0..639 on lines 0..479.
  - `aactive` is low on lines 480..524 regardless of `xx`.
- Edge transitions:
  - `hsync` falls on the edge where `xx` becomes 656 and rises where `xx` becomes 752.
  - `vsync` falls on the edge where (`xx`,`yy`) becomes (0,490) and rises where it becomes (0,492).
- Wrap boundary: the transition from (799,524) to (0,0) takes exactly one clock. `xx` never holds 800 and `yy` never holds 525.
- Reset mid-frame: the next frame after release begins at (0,0) with no partial line. `frame_cnt` restarts from 0, reading 1 after the first edge.

## Test plan
- Reset values: hold `rst_n`=0 for 5 clocks -> `xx`=799, `yy`=524, `aactive`=0, `hsync`=1, `vsync`=1, strobes 0, `frame_cnt`=0.
- Release: deassert `rst_n` -> first edge gives (0,0), `aactive`=1, `frame_start`=1, `frame_cnt`=1; next edge gives `xx`=1, `frame_start`=0.
- Line wrap: at (799,0) the next edge gives (0,1) with `line_start`=1. At `xx`=639 `aactive`=1; at `xx`=640 `aactive`=0. `hsync` is low for exactly 96 clocks, from `xx`=656 to 751.
- Vertical: `vsync` is low for exactly 1600 clocks, starting at (0,490). `aactive` is never high while `yy`≥480.
- Frame wrap: run 2 full frames -> `frame_start` pulses are exactly 420000 clocks apart; `frame_cnt` reads 1 then 2; a scoreboard confirms `xx`<800 and `yy`<525 every cycle.
- Mid-frame reset: pulse `rst_n` low asynchronously (not clock-aligned) at (300,200) -> outputs take reset values immediately; after release the raster restarts at (0,0) with `frame_cnt`=1.
